// File: rtl/generic_elastic_pipeline_pkg.sv
// Shared definitions for the elastic (valid/ready) delay pipeline.
package generic_elastic_pipeline_pkg;

  // Optional input skid buffer: depth and the occupancy type used to track it.
  localparam int SKID_DEPTH = 2;
  typedef logic [1:0] skid_cnt_t;
  localparam skid_cnt_t SKID_FULL = 2'd2;

  // OCCUPANCY must hold LATENCY stages plus a full skid without wrapping.
  function automatic bit occ_width_ok(input int count_width, input int latency);
    return (64'(1) << count_width) > 64'(latency + SKID_DEPTH);
  endfunction

endpackage

// File: rtl/generic_elastic_pipeline_if.sv
// One valid/ready stream. master drives data/valid, slave drives ready.
interface generic_elastic_pipeline_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/generic_elastic_stage.sv
// One elastic register stage: holds a word while the next stage is blocked,
// loads from upstream whenever it is empty or the next stage advances.
module generic_elastic_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             adv_next_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             adv_o
);

  logic valid_q;
  // Per-stage enable keeps these out of SRL inference anyway; the attribute makes it explicit.
  (* shreg_extract = "no" *) logic [WIDTH-1:0] data_q = '0;

  // An empty stage can always take a word, even while downstream is stalled.
  assign adv_o   = !valid_q || adv_next_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Valid bit follows upstream on every advance; cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i)      valid_q <= 1'b0;
    else if (adv_o) valid_q <= valid_i;
  end

  // Data only captured for real words, so bubbles never toggle the datapath.
  always_ff @(posedge clk_i) begin
    if (adv_o && valid_i) data_q <= data_i;
  end

endmodule

// File: rtl/generic_elastic_pipeline.sv
// Valid/ready delay pipeline, LATENCY stages deep, with bubble collapse.
// Optional feature macro: GENERIC_ELASTIC_PIPELINE_REG_READY_EN adds a 2-entry
// input skid buffer so that the upstream ready comes straight from a register.
module generic_elastic_pipeline
  import generic_elastic_pipeline_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int LATENCY     = 2,
  parameter int COUNT_WIDTH = 8   // needs 2**COUNT_WIDTH > LATENCY+2, see occ_width_ok()
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  generic_elastic_pipeline_if.slave  up_if,
  generic_elastic_pipeline_if.master dn_if,
  output logic [COUNT_WIDTH-1:0]     occupancy_o
);

  if (LATENCY == 0) begin : g_wire
    // Zero stages: plain wires, nothing is ever held.
    assign dn_if.data  = up_if.data;
    assign dn_if.valid = up_if.valid;
    assign up_if.ready = dn_if.ready;
    assign occupancy_o = '0;
  end else begin : g_pipe
    logic [LATENCY:0]            vld;
    logic [LATENCY:0][WIDTH-1:0] dat;
    logic [LATENCY+1:1]          adv;
    logic                        in_xfer;
    logic                        out_xfer;
    logic [COUNT_WIDTH-1:0]      occ_q, occ_d;

    assign adv[LATENCY+1] = dn_if.ready;

    for (genvar k = 1; k <= LATENCY; k++) begin : g_stage
      generic_elastic_stage #(.WIDTH(WIDTH)) u_stage (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (vld[k-1]),
        .data_i     (dat[k-1]),
        .adv_next_i (adv[k+1]),
        .valid_o    (vld[k]),
        .data_o     (dat[k]),
        .adv_o      (adv[k])
      );
    end

    assign dn_if.data  = dat[LATENCY];
    assign dn_if.valid = vld[LATENCY];
    assign out_xfer    = vld[LATENCY] && dn_if.ready;

`ifdef GENERIC_ELASTIC_PIPELINE_REG_READY_EN
    // Skid: slot0 is the oldest word. Words only land here when stage 1 is
    // blocked, so while it is non-empty every stage is full.
    logic [WIDTH-1:0] skid0_q = '0;
    logic [WIDTH-1:0] skid1_q = '0;
    skid_cnt_t        skid_cnt_q, skid_cnt_d;
    logic             ready_q;
    logic             skid_push, skid_pop;

    // Reset still forces ready low; O_READY never reaches this path.
    assign up_if.ready = ready_q && !rst_i;
    assign in_xfer     = up_if.valid && up_if.ready;
    assign skid_pop    = (skid_cnt_q != '0) && adv[1];
    // Bypass straight into stage 1 when nothing is queued ahead of the new word.
    assign skid_push   = in_xfer && !((skid_cnt_q == '0) && adv[1]);
    assign vld[0]      = (skid_cnt_q != '0) || in_xfer;
    assign dat[0]      = (skid_cnt_q != '0) ? skid0_q : up_if.data;
    assign skid_cnt_d  = skid_cnt_q + skid_cnt_t'(skid_push) - skid_cnt_t'(skid_pop);

    // Skid fill level and registered ready (ready while a slot is free next cycle).
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        skid_cnt_q <= '0;
        ready_q    <= 1'b1;
      end else begin
        skid_cnt_q <= skid_cnt_d;
        ready_q    <= (skid_cnt_d < SKID_FULL);
      end
    end

    // Skid storage: shift on pop, then write the new word behind what remains.
    always_ff @(posedge clk_i) begin
      if (skid_pop) skid0_q <= skid1_q;
      if (skid_push) begin
        if ((skid_cnt_q == 2'd1) && !skid_pop) skid1_q <= up_if.data;
        else                                   skid0_q <= up_if.data;
      end
    end
`else
    // Ready ripples combinationally from the output back through every stage.
    assign up_if.ready = adv[1] && !rst_i;
    assign in_xfer     = up_if.valid && up_if.ready;
    assign vld[0]      = up_if.valid;
    assign dat[0]      = up_if.data;
`endif

    // Occupancy tracks accepted-minus-emitted; simultaneous in/out cancels.
    always_comb begin
      occ_d = occ_q;
      if (in_xfer && !out_xfer)      occ_d = occ_q + COUNT_WIDTH'(1);
      else if (out_xfer && !in_xfer) occ_d = occ_q - COUNT_WIDTH'(1);
    end

    // Occupancy register.
    always_ff @(posedge clk_i) begin
      if (rst_i) occ_q <= '0;
      else       occ_q <= occ_d;
    end

    assign occupancy_o = occ_q;
  end

endmodule
